// File: rtl/contador_pkg.sv
// Shared constants, digit type and BCD saturation helper for the three-decade counter.
package contador_pkg;

  localparam int          BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam int          N_DIG   = 3;

  typedef logic [BCD_W-1:0] bcd_t;

  function automatic bcd_t sat_bcd(input bcd_t nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/digito_bcd.sv
// One decade of the BCD chain: holds a digit, counts on step_in and emits carry/borrow on step_out.
module digito_bcd
  import contador_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic step_in,
  input  logic up_down,
  input  logic load,
  input  bcd_t load_digit,
  output bcd_t digit,
  output logic step_out
);

  bcd_t digit_q, digit_d;

  // Out-of-range digits behave as 9 going up and as 0 going down, so the chain self-heals.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    digit_d  = digit_q;
    step_out = 1'b0;
    if (load) begin
      digit_d = sat_bcd(load_digit);
    end else if (step_in) begin
      if (up_down) begin
        if (digit_q >= BCD_MAX) begin
          digit_d  = '0;
          step_out = 1'b1;
        end else begin
          digit_d = digit_q + 4'd1;
        end
      end else begin
        if (digit_q == '0 || digit_q > BCD_MAX) begin
          digit_d  = BCD_MAX;
          step_out = 1'b1;
        end else begin
          digit_d = digit_q - 4'd1;
        end
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) digit_q <= '0;
    else      digit_q <= digit_d;
  end

  assign digit = digit_q;

endmodule

// File: rtl/contador_bcd_3dig.sv
// Three-decade BCD up/down counter with prescaler, load, tick and wrap pulses.
// Define CONTADOR_PAUSA_EN to treat en as an active-low push-button that toggles a run flag.
module contador_bcd_3dig
  import contador_pkg::*;
#(
  parameter int DIV  = 50_000_000,
  parameter int PS_W = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   up_down,
  input  logic                   load,
  input  logic [N_DIG*BCD_W-1:0] load_val,
  output logic [BCD_W-1:0]       bcd0,
  output logic [BCD_W-1:0]       bcd1,
  output logic [BCD_W-1:0]       bcd2,
  output logic                   tick,
  output logic                   wrap
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

  logic            run;
  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick_q, tick_d;
  logic            wrap_q, wrap_d;
  logic            step;
  logic [N_DIG:0]  carry;
  bcd_t            digits [N_DIG];

`ifdef CONTADOR_PAUSA_EN
  // Button idles high; the synchroniser and edge history reset to "released".
  logic sync1_q, sync2_q, prev_q, run_q, run_d;

  always_comb begin
    run_d = run_q ^ (prev_q & ~sync2_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      run_q   <= 1'b1;
    end else begin
      sync1_q <= en;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      run_q   <= run_d;
    end
  end

  assign run = run_q;
`else
  assign run = en;
`endif

  assign step     = run & (ps_q == PS_LAST);
  assign carry[0] = step & ~load;

  always_comb begin
    ps_d = ps_q;
    if (load)      ps_d = '0;
    else if (step) ps_d = '0;
    else if (run)  ps_d = ps_q + 1'b1;
    tick_d = carry[0];
    wrap_d = carry[N_DIG];
  end

  for (genvar i = 0; i < N_DIG; i++) begin : g_dig
    digito_bcd u_dig (
      .clk        (clk),
      .rst        (rst),
      .step_in    (carry[i]),
      .up_down    (up_down),
      .load       (load),
      .load_digit (load_val[i*BCD_W +: BCD_W]),
      .digit      (digits[i]),
      .step_out   (carry[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q   <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign bcd0 = digits[0];
  assign bcd1 = digits[1];
  assign bcd2 = digits[2];
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_contador_bcd_3dig.sv
// Directed bench for contador_bcd_3dig with DIV=4; a behavioural model feeds an expected-value queue.
module tb_contador_bcd_3dig;

  localparam int DIV  = 4;
  localparam int PS_W = 3;

  typedef struct {
    string      tag;
    logic [11:0] bcd;
    logic        tick;
    logic        wrap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        up_down = 1'b1;
  logic        load = 1'b0;
  logic [11:0] load_val = '0;
  logic [3:0]  bcd0, bcd1, bcd2;
  logic        tick, wrap;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  int m_ps  = 0;
  int m_val = 0;

  contador_bcd_3dig #(.DIV(DIV), .PS_W(PS_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_down  (up_down),
    .load     (load),
    .load_val (load_val),
    .bcd0     (bcd0),
    .bcd1     (bcd1),
    .bcd2     (bcd2),
    .tick     (tick),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  function automatic int sat_val(input logic [11:0] lv);
    int h, t, u;
    h = (int'(lv[11:8]) > 9) ? 9 : int'(lv[11:8]);
    t = (int'(lv[7:4])  > 9) ? 9 : int'(lv[7:4]);
    u = (int'(lv[3:0])  > 9) ? 9 : int'(lv[3:0]);
    return h * 100 + t * 10 + u;
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the current inputs, queue the result, then compare.
  task automatic step_cycle(input string tag);
    exp_t e;
    logic t, w;
    t = 1'b0;
    w = 1'b0;
    if (load) begin
      m_val = sat_val(load_val);
      m_ps  = 0;
    end else if (en) begin
      if (m_ps == DIV - 1) begin
        m_ps = 0;
        t    = 1'b1;
        if (up_down) begin
          w     = (m_val == 999);
          m_val = (m_val + 1) % 1000;
        end else begin
          w     = (m_val == 0);
          m_val = (m_val + 999) % 1000;
        end
      end else begin
        m_ps++;
      end
    end
    e.tag  = tag;
    e.bcd  = to_bcd(m_val);
    e.tick = t;
    e.wrap = w;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({e.tag, ".bcd"},  {bcd2, bcd1, bcd0}, e.bcd);
    check({e.tag, ".tick"}, {11'd0, tick}, {11'd0, e.tick});
    check({e.tag, ".wrap"}, {11'd0, wrap}, {11'd0, e.wrap});
  endtask

  initial begin
    // Reset state, checked before and across clock edges.
    #1 rst = 1'b0;
    #2;
    check("reset_async.bcd", {bcd2, bcd1, bcd0}, 12'h000);
    @(posedge clk); #1;
    check("reset_hold.bcd",  {bcd2, bcd1, bcd0}, 12'h000);
    check("reset_hold.tw",   {10'd0, tick, wrap}, 12'h000);
    @(negedge clk);
    rst = 1'b1;

    // Count up from zero: first step on the 4th edge, 010 after 40 cycles.
    en = 1'b1;
    up_down = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step_cycle("count_up");
      if (i == 3) check("before_first_step", {bcd2, bcd1, bcd0}, 12'h000);
      if (i == 4) check("first_step", {bcd2, bcd1, bcd0, tick}, 13'b0_0000_0000_0001_1);
      if (i == 40) check("after_40", {bcd2, bcd1, bcd0}, 12'h010);
    end

    // Load 998 and roll over 999 -> 000.
    load = 1'b1; load_val = 12'h998;
    step_cycle("load_998");
    load = 1'b0;
    check("loaded_998", {bcd2, bcd1, bcd0}, 12'h998);
    for (int i = 1; i <= 9; i++) begin
      step_cycle("wrap_up");
      if (i == 4) check("reach_999", {bcd2, bcd1, bcd0}, 12'h999);
      if (i == 8) check("wrap_up_pulse", {bcd2, bcd1, bcd0, tick, wrap}, 14'b0000_0000_0000_11);
      if (i == 9) check("wrap_up_clear", {10'd0, tick, wrap}, 12'h000);
    end

    // Load 000 and count down through 000 -> 999 -> 998.
    load = 1'b1; load_val = 12'h000; up_down = 1'b0;
    step_cycle("load_000");
    load = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step_cycle("wrap_down");
      if (i == 4) check("wrap_down_999", {bcd2, bcd1, bcd0, wrap}, {12'h999, 1'b1});
      if (i == 8) check("down_998", {bcd2, bcd1, bcd0, wrap}, {12'h998, 1'b0});
    end

    // Saturating load, then a load that collides with a step.
    load = 1'b1; load_val = 12'hA3F;
    step_cycle("load_sat");
    load = 1'b0;
    check("sat_939", {bcd2, bcd1, bcd0}, 12'h939);
    up_down = 1'b1;
    for (int i = 1; i <= 3; i++) step_cycle("pre_collide");
    load = 1'b1; load_val = 12'h123;
    step_cycle("load_collide");
    load = 1'b0;
    check("collide_no_tick", {bcd2, bcd1, bcd0, tick}, {12'h123, 1'b0});
    for (int i = 1; i <= 4; i++) begin
      step_cycle("after_collide");
      if (i == 3) check("restart_wait", {bcd2, bcd1, bcd0}, 12'h123);
      if (i == 4) check("restart_step", {bcd2, bcd1, bcd0, tick}, {12'h124, 1'b1});
    end

    // Hold at prescaler=2 for 10 cycles, then resume two cycles later.
    for (int i = 1; i <= 2; i++) step_cycle("pre_hold");
    en = 1'b0;
    for (int i = 1; i <= 10; i++) step_cycle("hold");
    check("held_digits", {bcd2, bcd1, bcd0}, 12'h124);
    en = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      step_cycle("resume");
      if (i == 2) check("resume_step", {bcd2, bcd1, bcd0, tick}, {12'h125, 1'b1});
    end

    // Asynchronous reset mid-cycle while tick is high.
    #2 rst = 1'b0;
    #1;
    check("async_rst.bcd", {bcd2, bcd1, bcd0}, 12'h000);
    check("async_rst.tw",  {10'd0, tick, wrap}, 12'h000);
    m_ps  = 0;
    m_val = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) step_cycle("post_reset");
    check("post_reset_001", {bcd2, bcd1, bcd0}, 12'h001);

    total++;
    assert (sb_q.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
